// File: rtl/alu_io_shifter_if.sv
// Operand load, ALU slice and result handshake bundle for alu_io_shifter.
// The slave modport is the shifter; master is the side driving it.
interface alu_io_shifter_if #(
   parameter int REG_BITS = 8,
   parameter int NSHIFT   = 2
);
   logic                  load_valid;
   logic                  load_ready;
   logic [REG_BITS-1:0]   load_data;
   logic                  load_pair;
   logic                  operand_valid;
   logic                  active;
   logic                  op_done;
   logic [NSHIFT-1:0]     data_in;
   logic [NSHIFT-1:0]     data_out;
   logic                  result_valid;
   logic                  result_ready;
   logic [2*REG_BITS-1:0] result_data;
   logic                  protocol_err;

   modport slave (
      input  load_valid, load_data, load_pair,
      input  active, op_done, data_out, result_ready,
      output load_ready, operand_valid, data_in,
      output result_valid, result_data, protocol_err
   );

   modport master (
      output load_valid, load_data, load_pair,
      output active, op_done, data_out, result_ready,
      input  load_ready, operand_valid, data_in,
      input  result_valid, result_data, protocol_err
   );
endinterface

// File: rtl/alu_io_shifter.sv
// Serialises a 1- or 2-byte operand to a bit-serial ALU in NSHIFT slices
// and reassembles the returned slices into a right-aligned result.
module alu_io_shifter #(
   parameter int REG_BITS = 8,
   parameter int NSHIFT   = 2
) (
   input logic             clk,
   input logic             rst_n,
   input logic             flush,
   alu_io_shifter_if.slave bus
);
   localparam int W   = 2 * REG_BITS;
   localparam int NSL = W / NSHIFT;
   localparam int HSL = REG_BITS / NSHIFT;
   localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSL - 1);

   typedef enum logic [2:0] {
      IDLE, FILL_HI, READY, SHIFT, RESULT
   } state_t;

   state_t        state, state_nx;
   logic [W-1:0]  operand;
   logic [W-1:0]  result;
   logic [CW-1:0] cnt;
   logic          pair;
   logic          sat;
   logic          perr;
   logic          cap;
   logic          err_set;
   logic          busy;

   assign busy = (state == READY) || (state == SHIFT);

   always_comb begin
      state_nx = state;
      cap      = 1'b0;
      err_set  = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.load_valid)
               state_nx = bus.load_pair ? FILL_HI : READY;
            err_set = bus.active | bus.op_done;
         end
         FILL_HI: begin
            if (bus.load_valid)
               state_nx = READY;
            err_set = bus.active | bus.op_done;
         end
         READY, SHIFT: begin
            if (bus.active) begin
               cap      = 1'b1;
               err_set  = sat;
               state_nx = bus.op_done ? RESULT : SHIFT;
            end
         end
         RESULT: begin
            if (bus.result_ready)
               state_nx = IDLE;
            err_set = bus.active | bus.op_done;
         end
         default: state_nx = IDLE;
      endcase
      if (flush)
         state_nx = IDLE;
   end

   // Unpaired operands read zero past the low byte regardless of contents.
   always_comb begin
      bus.data_in = '0;
      if (busy && bus.active && (pair || int'(cnt) < HSL))
         bus.data_in = operand[NSHIFT*int'(cnt) +: NSHIFT];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         operand <= '0;
         result  <= '0;
         cnt     <= '0;
         pair    <= 1'b0;
         sat     <= 1'b0;
         perr    <= 1'b0;
      end else if (flush) begin
         state   <= IDLE;
         operand <= '0;
         result  <= '0;
         cnt     <= '0;
         pair    <= 1'b0;
         sat     <= 1'b0;
         perr    <= 1'b0;
      end else begin
         state <= state_nx;
         if (err_set)
            perr <= 1'b1;
         if (state == IDLE && bus.load_valid) begin
            operand <= {{REG_BITS{1'b0}}, bus.load_data};
            pair    <= bus.load_pair;
            cnt     <= '0;
            sat     <= 1'b0;
            result  <= '0;
         end
         if (state == FILL_HI && bus.load_valid)
            operand[W-1:REG_BITS] <= bus.load_data;
         if (cap) begin
            result[NSHIFT*int'(cnt) +: NSHIFT] <= bus.data_out;
            if (cnt == LAST)
               sat <= 1'b1;
            else
               cnt <= cnt + 1'b1;
         end
         if (state == RESULT && bus.result_ready) begin
            operand <= '0;
            result  <= '0;
            cnt     <= '0;
            pair    <= 1'b0;
            sat     <= 1'b0;
         end
      end
   end

   assign bus.load_ready    = (state == IDLE) || (state == FILL_HI);
   assign bus.operand_valid = busy;
   assign bus.result_valid  = (state == RESULT);
   assign bus.result_data   = result;
   assign bus.protocol_err  = perr;
endmodule

// File: tb/tb_alu_io_shifter.sv
// Directed bench for alu_io_shifter.
// Hand-computed expected values.
module tb_alu_io_shifter;
   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   int   tests = 0;
   int   fails = 0;

   alu_io_shifter_if #(.REG_BITS(8), .NSHIFT(2)) bus ();

   alu_io_shifter #(.REG_BITS(8), .NSHIFT(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] b, input logic p);
      bus.load_valid = 1'b1;
      bus.load_data  = b;
      bus.load_pair  = p;
      tick();
      bus.load_valid = 1'b0;
      bus.load_pair  = 1'b0;
   endtask

   task automatic release_result();
      bus.result_ready = 1'b1;
      tick();
      bus.result_ready = 1'b0;
   endtask

   initial begin
      logic [1:0] e1 [4];
      logic [1:0] d1 [4];
      logic [1:0] e2 [8];
      logic [1:0] e5 [10];
      e1 = '{2'd0, 2'd1, 2'd3, 2'd2};
      d1 = '{2'd3, 2'd2, 2'd1, 2'd0};
      e2 = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
      e5 = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd0,
             2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

      rst_n = 1'b0;
      flush = 1'b0;
      bus.load_valid   = 1'b0;
      bus.load_data    = '0;
      bus.load_pair    = 1'b0;
      bus.active       = 1'b0;
      bus.op_done      = 1'b0;
      bus.data_out     = '0;
      bus.result_ready = 1'b0;
      #3;
      chk("rst_load_ready", bus.load_ready, 1);
      chk("rst_operand_valid", bus.operand_valid, 0);
      chk("rst_result_valid", bus.result_valid, 0);
      chk("rst_data_in", bus.data_in, 0);
      chk("rst_result_data", bus.result_data, 0);
      chk("rst_protocol_err", bus.protocol_err, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // single byte 0xB4
      load(8'hB4, 1'b0);
      chk("t1_operand_valid", bus.operand_valid, 1);
      chk("t1_load_ready", bus.load_ready, 0);
      for (int i = 0; i < 4; i++) begin
         bus.active   = 1'b1;
         bus.data_out = d1[i];
         bus.op_done  = (i == 3);
         #1;
         chk($sformatf("t1_data_in%0d", i), bus.data_in, e1[i]);
         tick();
      end
      bus.active  = 1'b0;
      bus.op_done = 1'b0;
      chk("t1_result_valid", bus.result_valid, 1);
      chk("t1_result_data", bus.result_data, 16'h001B);
      chk("t1_operand_valid_off", bus.operand_valid, 0);

      // hold result with load pressure
      bus.load_valid = 1'b1;
      bus.load_data  = 8'h55;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("hold_load_ready%0d", i), bus.load_ready, 0);
         chk($sformatf("hold_data%0d", i), bus.result_data, 16'h001B);
         tick();
      end
      bus.load_valid = 1'b0;
      release_result();
      chk("rel_result_valid", bus.result_valid, 0);
      chk("rel_load_ready", bus.load_ready, 1);
      chk("rel_result_data", bus.result_data, 0);

      // pair operand 0x1234, echoed
      load(8'h34, 1'b1);
      chk("t2_fill_load_ready", bus.load_ready, 1);
      chk("t2_fill_operand_valid", bus.operand_valid, 0);
      load(8'h12, 1'b0);
      chk("t2_operand_valid", bus.operand_valid, 1);
      for (int i = 0; i < 8; i++) begin
         bus.active   = 1'b1;
         bus.op_done  = (i == 7);
         bus.data_out = e2[i];
         #1;
         chk($sformatf("t2_data_in%0d", i), bus.data_in, e2[i]);
         tick();
      end
      bus.active  = 1'b0;
      bus.op_done = 1'b0;
      chk("t2_result_valid", bus.result_valid, 1);
      chk("t2_result_data", bus.result_data, 16'h1234);
      chk("t2_protocol_err", bus.protocol_err, 0);
      release_result();

      // early op_done on pair operand
      load(8'h34, 1'b1);
      load(8'h12, 1'b0);
      bus.active   = 1'b1;
      bus.data_out = 2'd1;
      tick();
      bus.data_out = 2'd2;
      bus.op_done  = 1'b1;
      tick();
      bus.active  = 1'b0;
      bus.op_done = 1'b0;
      chk("t3_result_valid", bus.result_valid, 1);
      chk("t3_result_data", bus.result_data, 16'h0009);
      release_result();

      // active in IDLE, then flush
      bus.active = 1'b1;
      #1;
      chk("t4_idle_data_in", bus.data_in, 0);
      tick();
      bus.active = 1'b0;
      chk("t4_err_set", bus.protocol_err, 1);
      tick();
      chk("t4_err_sticky", bus.protocol_err, 1);
      flush = 1'b1;
      bus.load_valid = 1'b1;
      bus.load_data  = 8'hAA;
      tick();
      flush = 1'b0;
      bus.load_valid = 1'b0;
      chk("t4_err_clear", bus.protocol_err, 0);
      chk("t4_flush_idle", bus.load_ready, 1);
      chk("t4_flush_no_load", bus.operand_valid, 0);

      // unpaired zero fill and terminal-count saturation
      load(8'hFF, 1'b0);
      for (int i = 0; i < 10; i++) begin
         bus.active   = 1'b1;
         bus.op_done  = (i == 9);
         bus.data_out = (i == 9) ? 2'd2 : 2'd1;
         #1;
         chk($sformatf("t5_data_in%0d", i), bus.data_in, e5[i]);
         if (i == 8)
            chk("t5_err_before_sat", bus.protocol_err, 0);
         tick();
      end
      bus.active  = 1'b0;
      bus.op_done = 1'b0;
      chk("t5_err_sat", bus.protocol_err, 1);
      chk("t5_result_data", bus.result_data, 16'h9555);
      release_result();
      flush = 1'b1;
      tick();
      flush = 1'b0;

      // async reset during SHIFT at cnt=2
      load(8'h34, 1'b1);
      load(8'h12, 1'b0);
      bus.active   = 1'b1;
      bus.data_out = 2'd3;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_load_ready", bus.load_ready, 1);
      chk("t6_operand_valid", bus.operand_valid, 0);
      chk("t6_data_in", bus.data_in, 0);
      chk("t6_result_valid", bus.result_valid, 0);
      chk("t6_result_data", bus.result_data, 0);
      bus.active = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_no_result_pulse", bus.result_valid, 0);
      load(8'hFF, 1'b0);
      for (int i = 0; i < 4; i++) begin
         bus.active   = 1'b1;
         bus.op_done  = (i == 3);
         bus.data_out = bus.data_in;
         #1;
         bus.data_out = bus.data_in;
         chk($sformatf("t6_data_in%0d", i), bus.data_in, 3);
         tick();
      end
      bus.active  = 1'b0;
      bus.op_done = 1'b0;
      chk("t6_result_valid_after", bus.result_valid, 1);
      chk("t6_result_data_after", bus.result_data, 16'h00FF);
      release_result();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
